// File: rtl/rf_scoreboard.sv
// Register-file write scoreboard: per-register pending-write counters,
// issue stall generation, writeback retirement and flush handling.
module rf_scoreboard #(
    parameter int CNT_W = 2,
    parameter int TOT_W = 7
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Flush,
    input  logic             Issue_Valid,
    input  logic [4:0]       Issue_A1,
    input  logic             Issue_Use1,
    input  logic [4:0]       Issue_A2,
    input  logic             Issue_Use2,
    input  logic             Issue_Wr,
    input  logic [4:0]       Issue_A3,
    input  logic             WB_Valid,
    input  logic [4:0]       WB_A3,
    output logic             Stall,
    output logic             Accept,
    output logic [31:0]      Busy_Vec,
    output logic [TOT_W-1:0] Inflight,
    output logic             Err_Underflow
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q [32];
    logic [CNT_W-1:0] cnt_d [32];
    logic [31:0]      busy_q;
    logic [31:0]      busy_d;
    logic [TOT_W-1:0] infl_q;
    logic [TOT_W-1:0] infl_d;
    logic             err_q;
    logic             err_d;

    logic        src1_hit;
    logic        src2_hit;
    logic        dst_full;
    logic        stall;
    logic        accept;
    logic        wb_hit;
    logic        any_inc;
    logic        any_dec;
    logic        underflow;
    logic [31:0] inc_v;
    logic [31:0] dec_v;

    // Hazard check looks only at registered counts; a same-cycle
    // writeback becomes visible in the RF one cycle later.
    always_comb begin
        src1_hit = Issue_Use1 & (Issue_A1 != 5'd0)
                 & (cnt_q[Issue_A1] != '0);
        src2_hit = Issue_Use2 & (Issue_A2 != 5'd0)
                 & (cnt_q[Issue_A2] != '0);
        dst_full = Issue_Wr & (Issue_A3 != 5'd0)
                 & (cnt_q[Issue_A3] == CNT_MAX);
        stall    = Issue_Valid & (src1_hit | src2_hit | dst_full);
        accept   = Issue_Valid & ~stall;
    end

    assign Stall  = stall;
    assign Accept = accept;

    always_comb begin
        wb_hit    = WB_Valid & (WB_A3 != 5'd0);
        any_inc   = accept & Issue_Wr & (Issue_A3 != 5'd0);
        any_dec   = wb_hit & (cnt_q[WB_A3] != '0);
        underflow = wb_hit & (cnt_q[WB_A3] == '0);
        inc_v     = '0;
        dec_v     = '0;
        for (int i = 1; i < 32; i++) begin
            inc_v[i] = any_inc & (Issue_A3 == 5'(i));
            dec_v[i] = any_dec & (WB_A3 == 5'(i));
        end
    end

    always_comb begin
        for (int i = 0; i < 32; i++) begin
            cnt_d[i] = cnt_q[i];
            unique case ({inc_v[i], dec_v[i]})
                2'b10:   cnt_d[i] = cnt_q[i] + CNT_ONE;
                2'b01:   cnt_d[i] = cnt_q[i] - CNT_ONE;
                default: cnt_d[i] = cnt_q[i];
            endcase
        end
        cnt_d[0] = '0;
        infl_d   = infl_q + TOT_W'(any_inc) - TOT_W'(any_dec);
        err_d    = err_q | (underflow & ~Flush);
        // Flush drops tracking but keeps the sticky error visible
        if (Flush) begin
            for (int i = 0; i < 32; i++) begin
                cnt_d[i] = '0;
            end
            infl_d = '0;
        end
        for (int i = 0; i < 32; i++) begin
            busy_d[i] = (cnt_d[i] != '0);
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < 32; i++) begin
                cnt_q[i] <= '0;
            end
            busy_q <= '0;
            infl_q <= '0;
            err_q  <= 1'b0;
        end else begin
            for (int i = 0; i < 32; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            busy_q <= busy_d;
            infl_q <= infl_d;
            err_q  <= err_d;
        end
    end

    assign Busy_Vec      = busy_q;
    assign Inflight      = infl_q;
    assign Err_Underflow = err_q;

endmodule

// File: tb/tb_rf_scoreboard.sv
// Self-checking bench for rf_scoreboard: reference counter model feeds
// a queue of expected registered state, checked after each clock edge.
module tb_rf_scoreboard;

    logic       Clk;
    logic       Reset;
    logic       Flush;
    logic       Issue_Valid;
    logic [4:0] Issue_A1;
    logic       Issue_Use1;
    logic [4:0] Issue_A2;
    logic       Issue_Use2;
    logic       Issue_Wr;
    logic [4:0] Issue_A3;
    logic       WB_Valid;
    logic [4:0] WB_A3;
    logic       Stall;
    logic       Accept;
    logic [31:0] Busy_Vec;
    logic [6:0] Inflight;
    logic       Err_Underflow;

    rf_scoreboard #(.CNT_W(2), .TOT_W(7)) dut (
        .Clk(Clk),
        .Reset(Reset),
        .Flush(Flush),
        .Issue_Valid(Issue_Valid),
        .Issue_A1(Issue_A1),
        .Issue_Use1(Issue_Use1),
        .Issue_A2(Issue_A2),
        .Issue_Use2(Issue_Use2),
        .Issue_Wr(Issue_Wr),
        .Issue_A3(Issue_A3),
        .WB_Valid(WB_Valid),
        .WB_A3(WB_A3),
        .Stall(Stall),
        .Accept(Accept),
        .Busy_Vec(Busy_Vec),
        .Inflight(Inflight),
        .Err_Underflow(Err_Underflow)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [31:0] busy;
        logic [6:0]  infl;
        logic        err;
    } exp_t;

    exp_t q[$];
    int   mcnt[32];
    bit   merr;
    int   n_tests;
    int   n_fail;
    logic s_obs;
    logic a_obs;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive, check combinational outputs against the model,
    // queue predicted state, then check registered outputs after the edge.
    task automatic cyc(input bit v, input bit u1, input bit [4:0] a1,
                       input bit u2, input bit [4:0] a2,
                       input bit wr, input bit [4:0] a3,
                       input bit wbv, input bit [4:0] wba,
                       input bit fl, input bit rst);
        bit   ms;
        bit   ma;
        bit   inc;
        bit   dec;
        bit   uf;
        int   sum;
        exp_t e;
        exp_t g;
        Issue_Valid = v;
        Issue_Use1  = u1;
        Issue_A1    = a1;
        Issue_Use2  = u2;
        Issue_A2    = a2;
        Issue_Wr    = wr;
        Issue_A3    = a3;
        WB_Valid    = wbv;
        WB_A3       = wba;
        Flush       = fl;
        Reset       = rst;
        #1;
        ms = v && ((u1 && a1 != 0 && mcnt[a1] != 0) ||
                   (u2 && a2 != 0 && mcnt[a2] != 0) ||
                   (wr && a3 != 0 && mcnt[a3] == 3));
        ma = v && !ms;
        s_obs = Stall;
        a_obs = Accept;
        chk("stall", Stall, ms);
        chk("accept", Accept, ma);
        if (rst) begin
            foreach (mcnt[i]) mcnt[i] = 0;
            merr = 0;
        end else if (fl) begin
            foreach (mcnt[i]) mcnt[i] = 0;
        end else begin
            inc = ma && wr && a3 != 0;
            dec = wbv && wba != 0 && mcnt[wba] != 0;
            uf  = wbv && wba != 0 && mcnt[wba] == 0;
            if (inc) mcnt[a3] = mcnt[a3] + 1;
            if (dec) mcnt[wba] = mcnt[wba] - 1;
            if (uf) merr = 1;
        end
        sum = 0;
        e.busy = '0;
        foreach (mcnt[i]) begin
            sum += mcnt[i];
            e.busy[i] = (mcnt[i] != 0);
        end
        e.infl = 7'(sum);
        e.err  = merr;
        q.push_back(e);
        @(posedge Clk);
        #1;
        if (q.size() == 0) begin
            chk("queue_empty", 1'b1, 1'b0);
        end else begin
            g = q.pop_front();
            chk("busy_vec", Busy_Vec, g.busy);
            chk("inflight", Inflight, g.infl);
            chk("err_uf", Err_Underflow, g.err);
        end
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic rst_cyc();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        foreach (mcnt[i]) mcnt[i] = 0;
        merr = 0;
        Reset = 1;
        Flush = 0;
        Issue_Valid = 0;
        Issue_A1 = 0;
        Issue_Use1 = 0;
        Issue_A2 = 0;
        Issue_Use2 = 0;
        Issue_Wr = 0;
        Issue_A3 = 0;
        WB_Valid = 0;
        WB_A3 = 0;
        @(posedge Clk);
        #1;

        // reset with toggling inputs
        for (int k = 0; k < 3; k++) begin
            cyc(1'($urandom), 1'($urandom), 5'($urandom),
                1'($urandom), 5'($urandom), 1'($urandom),
                5'($urandom), 1'($urandom), 5'($urandom),
                1'($urandom), 1);
        end
        chk("rst_busy", Busy_Vec, 32'h0);
        chk("rst_infl", Inflight, 7'd0);
        chk("rst_err", Err_Underflow, 1'b0);
        cyc(1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_nostall", s_obs, 1'b0);

        // RAW hazard on $8
        rst_cyc();
        cyc(1, 0, 0, 0, 0, 1, 8, 0, 0, 0, 0);
        chk("raw_busy_c2", Busy_Vec[8], 1'b1);
        cyc(1, 1, 8, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("raw_stall_c2", s_obs, 1'b1);
        cyc(1, 1, 8, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("raw_stall_c3", s_obs, 1'b1);
        cyc(1, 1, 8, 0, 0, 0, 0, 1, 8, 0, 0);
        chk("raw_stall_c4", s_obs, 1'b1);
        chk("raw_busy_c5", Busy_Vec[8], 1'b0);
        cyc(1, 1, 8, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("raw_accept_c5", a_obs, 1'b1);

        // destination saturation on $3
        rst_cyc();
        for (int k = 0; k < 3; k++) cyc(1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0);
        chk("sat_infl3", Inflight, 7'd3);
        cyc(1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0);
        chk("sat_stall", s_obs, 1'b1);
        cyc(1, 0, 0, 0, 0, 1, 3, 1, 3, 0, 0);
        chk("sat_stall_wb", s_obs, 1'b1);
        chk("sat_infl2", Inflight, 7'd2);
        cyc(1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0);
        chk("sat_accept", a_obs, 1'b1);
        chk("sat_infl_end", Inflight, 7'd3);

        // simultaneous inc/dec and $0 traffic
        rst_cyc();
        cyc(1, 0, 0, 0, 0, 1, 9, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 1, 9, 1, 9, 0, 0);
        chk("same_busy9", Busy_Vec[9], 1'b1);
        chk("same_infl", Inflight, 7'd1);
        cyc(1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
        chk("zero_infl", Inflight, 7'd1);
        chk("zero_err", Err_Underflow, 1'b0);

        // underflow, flush keeps error, reset clears it
        rst_cyc();
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 12, 0, 0);
        chk("uf_set", Err_Underflow, 1'b1);
        cyc(1, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0);
        chk("uf_sticky", Err_Underflow, 1'b1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        chk("fl_busy", Busy_Vec, 32'h0);
        chk("fl_infl", Inflight, 7'd0);
        chk("fl_err", Err_Underflow, 1'b1);
        rst_cyc();
        chk("rst_err_clr", Err_Underflow, 1'b0);

        // $0 reads and unused ports, flush drops issue
        cyc(1, 0, 0, 0, 0, 1, 4, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 4, 0, 0, 0, 0, 0, 0);
        chk("zero_read", s_obs, 1'b0);
        cyc(1, 0, 0, 0, 0, 1, 10, 0, 0, 1, 0);
        chk("fl_issue", Busy_Vec, 32'h0);
        chk("fl_wb_noerr", Err_Underflow, 1'b0);

        // random traffic on a few registers, model-checked
        rst_cyc();
        for (int k = 0; k < 400; k++) begin
            cyc(1'($urandom), 1'($urandom), 5'($urandom_range(0, 6)),
                1'($urandom), 5'($urandom_range(0, 6)),
                1'($urandom), 5'($urandom_range(0, 6)),
                ($urandom_range(0, 2) != 0), 5'($urandom_range(0, 6)),
                ($urandom_range(0, 40) == 0), 1'b0);
        end

        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
